// File: rtl/grid_cursor_nav.sv
// grid_cursor_nav
//   Cursor for a COLS x ROWS keypad grid. Each cell can be enabled or disabled
//   through a per-cell mask. A single held direction moves the cursor once on
//   the first edge. After REPEAT_DELAY cycles it auto-repeats every
//   REPEAT_RATE cycles. Moves skip disabled cells. If the current cell becomes
//   disabled, the cursor relocates to the lowest-index enabled cell.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-low reset
//   cell_mask     per-cell enable, bit index y*COLS+x, 1 = enabled
//   dir_up/down/left/right  debounced level inputs (up = row-1, left = col-1)
//   select        debounced level; a rising edge requests selection
//   pos_x, pos_y  registered cursor column / row
//   val           registered cell index pos_y*COLS+pos_x
//   cursor_valid  registered; cell under the cursor is enabled
//   sel_valid     one-cycle strobe for an accepted selection
//   sel_val       index of the last accepted selection (held)
//   state_dbg     repeat FSM state: 0 IDLE, 1 DELAY, 2 REPEAT
//
// Handshake: sel_valid/sel_val is a valid-only strobe with no ready. The
// consumer must take sel_val in the single cycle sel_valid is high. sel_val
// stays stable until the next accepted selection.
module grid_cursor_nav #(
  parameter int COLS         = 6,
  parameter int ROWS         = 4,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  localparam int XW          = $clog2(COLS),
  localparam int YW          = $clog2(ROWS),
  localparam int VW          = $clog2(COLS * ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS*ROWS-1:0]   cell_mask,
  input  logic                   dir_up,
  input  logic                   dir_down,
  input  logic                   dir_left,
  input  logic                   dir_right,
  input  logic                   select,
  output logic [XW-1:0]          pos_x,
  output logic [YW-1:0]          pos_y,
  output logic [VW-1:0]          val,
  output logic                   cursor_valid,
  output logic                   sel_valid,
  output logic [VW-1:0]          sel_val,
  output logic [1:0]             state_dbg
);

  localparam int CELLS = COLS * ROWS;
  localparam int CMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW    = $clog2(CMAX);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [3:0]     dir_prev;
  logic           sel_prev;

  logic [3:0]     dir_vec;
  logic [3:0]     dir_oh;
  logic [3:0]     prev_oh;
  logic           hold;
  logic           move;
  logic [VW-1:0]  cur_idx;
  logic           cur_en;
  logic           any_en;
  logic [VW-1:0]  first_idx;
  logic [XW-1:0]  nx_x;
  logic [YW-1:0]  nx_y;
  logic [VW-1:0]  nx_idx;
  logic           sel_fire;

  function automatic logic [VW-1:0] cell_idx(input int x, input int y);
    return VW'(y * COLS + x);
  endfunction

  // Walk along the row from x, skipping disabled cells. Returns x if no enabled
  // cell is reachable.
  function automatic logic [XW-1:0] step_x(input logic [XW-1:0] x,
                                           input logic [YW-1:0] y,
                                           input logic right,
                                           input logic [CELLS-1:0] mask);
    logic [XW-1:0] r;
    logic          hit;
    int            c;
    r   = x;
    hit = 1'b0;
    for (int s = 1; s < COLS; s++) begin
      c = right ? int'(x) + s : int'(x) - s;
      if (WRAP != 0) begin
        if (c >= COLS) c = c - COLS;
        else if (c < 0) c = c + COLS;
      end
      if (!hit && c >= 0 && c < COLS) begin
        if (mask[cell_idx(c, int'(y))]) begin
          hit = 1'b1;
          r   = XW'(c);
        end
      end
    end
    return r;
  endfunction

  // Walk along the column from y, in the same way as step_x.
  function automatic logic [YW-1:0] step_y(input logic [XW-1:0] x,
                                           input logic [YW-1:0] y,
                                           input logic down,
                                           input logic [CELLS-1:0] mask);
    logic [YW-1:0] r;
    logic          hit;
    int            c;
    r   = y;
    hit = 1'b0;
    for (int s = 1; s < ROWS; s++) begin
      c = down ? int'(y) + s : int'(y) - s;
      if (WRAP != 0) begin
        if (c >= ROWS) c = c - ROWS;
        else if (c < 0) c = c + ROWS;
      end
      if (!hit && c >= 0 && c < ROWS) begin
        if (mask[cell_idx(int'(x), c)]) begin
          hit = 1'b1;
          r   = YW'(c);
        end
      end
    end
    return r;
  endfunction

  // Only a single held direction counts. Two or more at once count as none.
  assign dir_vec = {dir_up, dir_down, dir_left, dir_right};
  assign dir_oh  = $onehot(dir_vec)  ? dir_vec  : 4'b0000;
  assign prev_oh = $onehot(dir_prev) ? dir_prev : 4'b0000;
  assign hold    = (dir_oh != 4'b0000) && (dir_oh == prev_oh);

  assign move = ((state == IDLE)   && (dir_oh != 4'b0000)) ||
                ((state == DELAY)  && hold && (cnt == DELAY_LAST)) ||
                ((state == REPEAT) && hold && (cnt == RATE_LAST));

  assign cur_idx  = cell_idx(int'(pos_x), int'(pos_y));
  assign cur_en   = cell_mask[cur_idx];
  assign any_en   = |cell_mask;
  assign sel_fire = select & ~sel_prev & cursor_valid;

  // Lowest-index enabled cell, the relocation target.
  always_comb begin
    first_idx = '0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (cell_mask[i]) first_idx = VW'(i);
    end
  end

  // Relocation wins over a move in the same cycle. An all-zero mask holds.
  always_comb begin
    nx_x = pos_x;
    nx_y = pos_y;
    if (!cur_en) begin
      if (any_en) begin
        nx_x = XW'(int'(first_idx) % COLS);
        nx_y = YW'(int'(first_idx) / COLS);
      end
    end else if (move) begin
      if (dir_oh[0])      nx_x = step_x(pos_x, pos_y, 1'b1, cell_mask);
      else if (dir_oh[1]) nx_x = step_x(pos_x, pos_y, 1'b0, cell_mask);
      else if (dir_oh[2]) nx_y = step_y(pos_x, pos_y, 1'b1, cell_mask);
      else if (dir_oh[3]) nx_y = step_y(pos_x, pos_y, 1'b0, cell_mask);
    end
  end

  assign nx_idx = cell_idx(int'(nx_x), int'(nx_y));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dir_prev     <= 4'b0000;
      sel_prev     <= 1'b0;
      pos_x        <= '0;
      pos_y        <= '0;
      val          <= '0;
      cursor_valid <= 1'b0;
      sel_valid    <= 1'b0;
      sel_val      <= '0;
    end else begin
      dir_prev <= dir_vec;
      sel_prev <= select;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (dir_oh != 4'b0000) state <= DELAY;
        end
        DELAY: begin
          if (!hold) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DELAY_LAST) begin
            state <= REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REPEAT: begin
          if (!hold) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == RATE_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      pos_x        <= nx_x;
      pos_y        <= nx_y;
      val          <= nx_idx;
      cursor_valid <= cell_mask[nx_idx];

      // sel_val captures the pre-move index.
      sel_valid <= sel_fire;
      if (sel_fire) sel_val <= val;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_grid_cursor_nav.sv
module tb_grid_cursor_nav;

  localparam int COLS  = 6;
  localparam int ROWS  = 4;
  localparam int D     = 8;
  localparam int R     = 3;
  localparam int CELLS = COLS * ROWS;
  localparam logic [CELLS-1:0] FULL = {CELLS{1'b1}};

  logic             clk;
  logic             rst;
  logic [CELLS-1:0] cell_mask;
  logic             dir_up, dir_down, dir_left, dir_right, select;

  // instance 0: WRAP=1, instance 1: WRAP=0, same inputs
  logic [2:0] px0, px1;
  logic [1:0] py0, py1;
  logic [4:0] v0, v1, sval0, sval1;
  logic       cv0, cv1, sv0, sv1;
  logic [1:0] st0, st1;

  int errors = 0;
  int checks = 0;

  // reference model state, index 0 = wrapping instance
  int         m_x[2], m_y[2], m_sval[2], m_n[2];
  logic       m_cv[2], m_sv[2], m_act[2];
  logic [3:0] m_dir[2];
  logic       m_sp;

  grid_cursor_nav #(.COLS(COLS), .ROWS(ROWS), .WRAP(1), .REPEAT_DELAY(D), .REPEAT_RATE(R)) dut_wrap (
    .clk(clk), .rst(rst), .cell_mask(cell_mask),
    .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
    .select(select), .pos_x(px0), .pos_y(py0), .val(v0), .cursor_valid(cv0),
    .sel_valid(sv0), .sel_val(sval0), .state_dbg(st0)
  );

  grid_cursor_nav #(.COLS(COLS), .ROWS(ROWS), .WRAP(0), .REPEAT_DELAY(D), .REPEAT_RATE(R)) dut_sat (
    .clk(clk), .rst(rst), .cell_mask(cell_mask),
    .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
    .select(select), .pos_x(px1), .pos_y(py1), .val(v1), .cursor_valid(cv1),
    .sel_valid(sv1), .sel_val(sval1), .state_dbg(st1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_sval[i] = 0; m_n[i] = 0;
      m_cv[i] = 1'b0; m_sv[i] = 1'b0; m_act[i] = 1'b0; m_dir[i] = 4'b0;
    end
    m_sp = 1'b0;
  endtask

  // One clock edge, from the rules: first edge of a single held direction
  // moves, then after D edges, then every R edges. Any change drops the run.
  task automatic model_step();
    logic [3:0] dv, d;
    logic       rise, mv, found;
    int         pre, dx, dy, len, cx, cy, nx, ny;
    dv   = {dir_up, dir_down, dir_left, dir_right};
    d    = ($countones(dv) == 1) ? dv : 4'b0;
    rise = select && !m_sp;
    m_sp = select;
    for (int i = 0; i < 2; i++) begin
      mv = 1'b0;
      if (!m_act[i]) begin
        if (d != 4'b0) begin mv = 1'b1; m_act[i] = 1'b1; m_dir[i] = d; m_n[i] = 0; end
      end else if (d == m_dir[i]) begin
        m_n[i]++;
        if (m_n[i] == D || (m_n[i] > D && (m_n[i] - D) % R == 0)) mv = 1'b1;
      end else begin
        m_act[i] = 1'b0;
      end
      pre = m_y[i] * COLS + m_x[i];
      m_sv[i] = rise && m_cv[i];
      if (m_sv[i]) m_sval[i] = pre;
      if (!cell_mask[pre]) begin
        found = 1'b0;
        for (int k = 0; k < CELLS; k++)
          if (!found && cell_mask[k]) begin found = 1'b1; m_x[i] = k % COLS; m_y[i] = k / COLS; end
      end else if (mv) begin
        dx  = d[0] ? 1 : (d[1] ? -1 : 0);
        dy  = d[2] ? 1 : (d[3] ? -1 : 0);
        len = (dx != 0) ? COLS : ROWS;
        found = 1'b0; nx = m_x[i]; ny = m_y[i];
        for (int s = 1; s < len; s++) begin
          cx = m_x[i] + dx * s;
          cy = m_y[i] + dy * s;
          if (i == 0) begin cx = (cx + COLS) % COLS; cy = (cy + ROWS) % ROWS; end
          if (!found && cx >= 0 && cx < COLS && cy >= 0 && cy < ROWS && cell_mask[cy * COLS + cx]) begin
            found = 1'b1; nx = cx; ny = cy;
          end
        end
        m_x[i] = nx; m_y[i] = ny;
      end
      m_cv[i] = cell_mask[m_y[i] * COLS + m_x[i]];
    end
  endtask

  task automatic compare_all();
    chk("pos_x wrap", px0, m_x[0]);   chk("pos_x sat", px1, m_x[1]);
    chk("pos_y wrap", py0, m_y[0]);   chk("pos_y sat", py1, m_y[1]);
    chk("val wrap", v0, m_y[0] * COLS + m_x[0]);
    chk("val sat", v1, m_y[1] * COLS + m_x[1]);
    chk("cursor_valid wrap", cv0, m_cv[0]); chk("cursor_valid sat", cv1, m_cv[1]);
    chk("sel_valid wrap", sv0, m_sv[0]);    chk("sel_valid sat", sv1, m_sv[1]);
    chk("sel_val wrap", sval0, m_sval[0]);  chk("sel_val sat", sval1, m_sval[1]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_dirs(input logic [3:0] v);
    {dir_up, dir_down, dir_left, dir_right} = v;
  endtask

  // d: 0 right, 1 left, 2 down, 3 up
  task automatic press(input int d);
    set_dirs(4'b0001 << d);
    tick();
    set_dirs(4'b0000);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    chk("reset pos_x", px0, 0);  chk("reset pos_y", py1, 0);
    chk("reset val", v0, 0);     chk("reset sel_valid", sv1, 0);
    chk("reset sel_val", sval0, 0);
    chk("reset state wrap", st0, 0); chk("reset state sat", st1, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; cell_mask = FULL; select = 1'b0;
    set_dirs(4'b0000);
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // six right presses from (0,0)
    for (int p = 1; p <= 6; p++) begin
      press(0);
      chk("right seq x wrap", px0, p % 6);
      chk("right seq y wrap", py0, 0);
      chk("right seq x sat", px1, (p < 5) ? p : 5);
    end
    chk("right seq final val", v0, 0);

    // saturating edges at (0,0) and (5,3)
    do_reset();
    press(1);
    chk("sat left x", px1, 0); chk("wrap left x", px0, 5);
    press(3);
    chk("sat up y", py1, 0);   chk("wrap up val", v0, 23);
    do_reset();
    repeat (5) press(0);
    repeat (3) press(2);
    press(0);
    chk("sat right corner val", v1, 23);
    chk("wrap right corner val", v0, 18);

    // skipping disabled cells (2,1) and (3,1)
    do_reset();
    press(0); press(2);
    cell_mask = FULL & ~(24'h1 << 8) & ~(24'h1 << 9);
    press(0);
    chk("skip right x", px0, 4); chk("skip right val", v0, 10); chk("skip right val sat", v1, 10);
    press(1);
    chk("skip left val", v0, 7); chk("skip left val sat", v1, 7);

    // hold-to-repeat, full hold then release at k+12
    cell_mask = FULL;
    do_reset();
    dir_down = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick();
      chk("hold y wrap", py0, (e < 8) ? 1 : (e < 11) ? 2 : (e < 14) ? 3 : 0);
      chk("hold y sat", py1, (e < 8) ? 1 : (e < 11) ? 2 : 3);
      if (e == 8) chk("hold state repeat", st0, 2);
    end
    dir_down = 1'b0;
    tick();
    do_reset();
    dir_down = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      if (e == 13) dir_down = 1'b0;
      tick();
      chk("release y", py0, (e < 8) ? 1 : (e < 11) ? 2 : 3);
    end

    // relocation and all-zero mask
    do_reset();
    cell_mask = FULL & ~24'h1F;
    tick();
    chk("reloc x", px0, 5); chk("reloc val", v0, 5); chk("reloc val sat", v1, 5);
    cell_mask = '0;
    tick();
    chk("zero mask cv", cv0, 0); chk("zero mask hold val", v0, 5);
    select = 1'b1;
    tick();
    chk("zero mask no sel", sv0, 0);
    select = 1'b0;
    tick();

    // select at val 9, held select, up+left together
    cell_mask = FULL;
    do_reset();
    repeat (3) press(0);
    press(2);
    select = 1'b1;
    tick();
    chk("sel pulse", sv0, 1); chk("sel val", sval0, 9); chk("sel val sat", sval1, 9);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("sel held no refire", sv0, 0);
    end
    select = 1'b0;
    set_dirs(4'b1010);
    tick();
    chk("multi-hot val", v0, 9); chk("multi-hot state", st0, 0); chk("multi-hot state sat", st1, 0);
    tick();
    set_dirs(4'b0000);
    tick();

    // randomized run against the model
    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 9))
          0, 1:    set_dirs(4'b0000);
          8, 9:    set_dirs(4'($urandom_range(0, 15)));
          default: set_dirs(4'b0001 << $urandom_range(0, 3));
        endcase
      end
      if ($urandom_range(0, 3) == 0) select = ~select;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 9))
          0:       cell_mask = '0;
          1, 2, 3: cell_mask = FULL;
          default: begin
            cell_mask = FULL;
            repeat ($urandom_range(1, 6)) cell_mask[$urandom_range(0, CELLS - 1)] = 1'b0;
          end
        endcase
      end
      if ($urandom_range(0, 79) == 0) do_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
